// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster timing bundle between the sync generator and its video consumers
interface vga_sync_gen_if;
  logic       enable;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       visible;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;
  modport master (
    input  enable,
    output pix_x, pix_y, visible, hsync, vsync, line_start, frame_start, frame_count
  );
  modport slave (
    output enable,
    input  pix_x, pix_y, visible, hsync, vsync, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator with pixel coordinates, sync, strobes and frame counter
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int CLK_DIV   = 1
) (
  input  logic           clock,
  input  logic           reset,
  vga_sync_gen_if.master vga
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;
  logic [9:0] x, y;
  logic [DW-1:0] div_cnt;
  logic [7:0] frames;
  logic fresh, run, tick, x_last, y_last;
  always_ff @(posedge clock) state <= state_next;
  always_comb begin
    state_next = reset ? IDLE : RUN;
    run = state == RUN;
    tick = run && vga.enable && div_cnt == DW'(CLK_DIV - 1);
    x_last = x == 10'(H_TOTAL - 1);
    y_last = y == 10'(V_TOTAL - 1);
    vga.pix_x = x;
    vga.pix_y = y;
    vga.visible = run && x < 10'(H_VISIBLE) && y < 10'(V_VISIBLE);
    vga.hsync = (run && x >= 10'(H_VISIBLE + H_FRONT) && x < 10'(H_VISIBLE + H_FRONT + H_SYNC)) ? SYNC_POL : ~SYNC_POL;
    vga.vsync = (run && y >= 10'(V_VISIBLE + V_FRONT) && y < 10'(V_VISIBLE + V_FRONT + V_SYNC)) ? SYNC_POL : ~SYNC_POL;
    vga.line_start = run && vga.enable && fresh && x == '0;
    vga.frame_start = vga.line_start && y == '0;
    vga.frame_count = frames;
  end
  // fresh marks a pixel whose first enabled clock has not yet been seen
  always_ff @(posedge clock) begin
    if (reset) begin
      x <= '0;
      y <= '0;
      div_cnt <= '0;
      frames <= '0;
      fresh <= 1'b1;
    end else if (run && vga.enable) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      fresh <= tick;
      if (tick) begin
        x <= x_last ? '0 : x + 1'b1;
        if (x_last) y <= y_last ? '0 : y + 1'b1;
        if (x_last && y_last) frames <= frames + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized scoreboard bench over three timing configurations
module tb_vga_sync_gen;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       vis;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic [2:0] rst;
  logic [2:0] en;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  vga_sync_gen_if bus0 ();
  vga_sync_gen_if bus1 ();
  vga_sync_gen_if bus2 ();
  assign bus0.enable = en[0];
  assign bus1.enable = en[1];
  assign bus2.enable = en[2];
  vga_sync_gen dut0 (.clock(clock), .reset(rst[0]), .vga(bus0));
  vga_sync_gen #(.H_VISIBLE(8), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
                 .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)) dut1 (.clock(clock), .reset(rst[1]), .vga(bus1));
  vga_sync_gen #(.H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                 .V_VISIBLE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
                 .SYNC_POL(1'b1), .CLK_DIV(2)) dut2 (.clock(clock), .reset(rst[2]), .vga(bus2));
  int hv [3] = '{640, 8, 10};
  int hf [3] = '{16, 1, 2};
  int hw [3] = '{96, 1, 3};
  int hb [3] = '{48, 1, 2};
  int vv [3] = '{480, 4, 5};
  int vf [3] = '{10, 1, 1};
  int vw [3] = '{2, 1, 2};
  int vb [3] = '{33, 1, 1};
  bit pol [3] = '{1'b0, 1'b0, 1'b1};
  int div [3] = '{1, 1, 2};
  // Model: linear pixel index within the frame, sub-pixel clock count, frame counter
  bit run [3];
  int p [3];
  int d [3];
  int fc [3];
  bit fresh [3];
  obs_t q0 [$];
  obs_t q1 [$];
  obs_t q2 [$];
  function automatic obs_t predict(int k, bit e);
    obs_t o;
    int ht = hv[k] + hf[k] + hw[k] + hb[k];
    int x = p[k] % ht;
    int y = p[k] / ht;
    o.x = 10'(x);
    o.y = 10'(y);
    o.vis = run[k] && x < hv[k] && y < vv[k];
    o.hs = (run[k] && x >= hv[k] + hf[k] && x < hv[k] + hf[k] + hw[k]) ? pol[k] : !pol[k];
    o.vs = (run[k] && y >= vv[k] + vf[k] && y < vv[k] + vf[k] + vw[k]) ? pol[k] : !pol[k];
    o.ls = run[k] && e && fresh[k] && x == 0;
    o.fs = o.ls && y == 0;
    o.fc = 8'(fc[k]);
    return o;
  endfunction
  task automatic advance(int k, bit r, bit e);
    int n = (hv[k] + hf[k] + hw[k] + hb[k]) * (vv[k] + vf[k] + vw[k] + vb[k]);
    if (r) begin
      run[k] = 1'b0; p[k] = 0; d[k] = 0; fc[k] = 0; fresh[k] = 1'b1;
    end else if (!run[k]) begin
      run[k] = 1'b1;
    end else if (e) begin
      if (d[k] == div[k] - 1) begin
        d[k] = 0;
        p[k] = (p[k] + 1) % n;
        if (p[k] == 0) fc[k] = (fc[k] + 1) % 256;
        fresh[k] = 1'b1;
      end else begin
        d[k] = d[k] + 1;
        fresh[k] = 1'b0;
      end
    end
  endtask
  task automatic compare(int k, obs_t want, obs_t got);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL inst%0d cycle %0d got x=%0d y=%0d vis=%b hs=%b vs=%b ls=%b fs=%b fc=%0d want x=%0d y=%0d vis=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
               k, cyc, got.x, got.y, got.vis, got.hs, got.vs, got.ls, got.fs, got.fc,
               want.x, want.y, want.vis, want.hs, want.vs, want.ls, want.fs, want.fc);
    end
  endtask
  task automatic underflow(int k);
    checks++;
    failures++;
    $display("FAIL inst%0d cycle %0d scoreboard empty got output want queued expectation", k, cyc);
  endtask
  initial begin
    @(posedge clock);
    forever begin
      @(negedge clock);
      if (q0.size() == 0) underflow(0);
      else compare(0, q0.pop_front(), {bus0.pix_x, bus0.pix_y, bus0.visible, bus0.hsync, bus0.vsync, bus0.line_start, bus0.frame_start, bus0.frame_count});
      if (q1.size() == 0) underflow(1);
      else compare(1, q1.pop_front(), {bus1.pix_x, bus1.pix_y, bus1.visible, bus1.hsync, bus1.vsync, bus1.line_start, bus1.frame_start, bus1.frame_count});
      if (q2.size() == 0) underflow(2);
      else compare(2, q2.pop_front(), {bus2.pix_x, bus2.pix_y, bus2.visible, bus2.hsync, bus2.vsync, bus2.line_start, bus2.frame_start, bus2.frame_count});
    end
  end
  initial begin
    rst = 3'b111;
    en = 3'b000;
    @(posedge clock);
    for (int k = 0; k < 3; k++) advance(k, 1'b1, 1'b0);
    for (int c = 0; c < 24000; c++) begin
      #2;
      cyc = c;
      rst[0] = c < 2 || $urandom_range(0, 2999) == 0;
      en[0] = $urandom_range(0, 9) != 0;
      rst[1] = c < 2;
      en[1] = $urandom_range(0, 49) != 0;
      rst[2] = c < 2 || $urandom_range(0, 499) == 0;
      en[2] = $urandom_range(0, 4) != 0;
      q0.push_back(predict(0, en[0]));
      q1.push_back(predict(1, en[1]));
      q2.push_back(predict(2, en[2]));
      for (int k = 0; k < 3; k++) advance(k, rst[k], en[k]);
      @(posedge clock);
    end
    #1;
    checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending expectations want 0", q0.size() + q1.size() + q2.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
